dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the single-port data memory. Requester 0 is the CPU load/store path; requester 1 is the program-loader/debug port. The block sits between both requesters and the memory. It grants one access per cycle, supports short locked bursts for the loader, and returns read data one cycle after acceptance on the winning requester's response channel.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width
- LOCK_MAX, 8, maximum accepted beats per locked burst (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  2  per-requester access request
- req_ready  out  2  per-requester acceptance, one-hot or zero
- req_we  in  2  1 = write, 0 = read
- req_lock  in  2  hold grant after this beat (burst)
- req_addr  in  2×ADDR_WIDTH  access address
- req_wdata  in  2×DATA_WIDTH  write data
- rsp_valid  out  2  response strobe, one cycle after acceptance
- rsp_rdata  out  DATA_WIDTH  read data, shared, qualified by rsp_valid
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid cycle after mem_en

## Operation
- Accept condition for requester i is req_valid[i] && req_ready[i]. At most one is accepted per cycle.
- mem_en equals the accept signal. mem_we, mem_addr and mem_wdata are muxed combinationally from the granted requester. All mem_* outputs are 0 when nothing is accepted.
- FSM states IDLE and LOCKED, with registers owner (1 bit), last_grant (1 bit) and lock_cnt ($clog2(LOCK_MAX+1) bits).
- IDLE grant rule:
  - Exactly one requester is valid: grant it.
  - Both are valid: grant !last_grant (round-robin).
- On accept in IDLE:
  - last_grant ← winner.
  - If req_lock[winner] and LOCK_MAX > 1: go to LOCKED, owner ← winner, lock_cnt ← 1.
- LOCKED:
  - Only owner can be granted, even when owner is idle.
  - The other requester's req_ready stays 0.
  - On each owner accept, lock_cnt increments.
  - Return to IDLE when:
    - an accepted beat has req_lock = 0, or
    - lock_cnt reaches LOCK_MAX on an accept (forced release).
  - On forced release, last_grant ← owner, so the other requester wins the next tie.
- Response: rsp_valid[i] pulses in the cycle after requester i's accept, for both reads and writes.
  - Reads: rsp_rdata = mem_rdata.
  - Writes: rsp_rdata = 0.
  - Back-to-back accepts give back-to-back responses with no bubble.
- Requesters hold req_* stable while valid && !ready. The arbiter does not check this.

## Timing
- Acceptance is combinational from req_valid and registered state, in the same cycle.
- Response latency is exactly 1 cycle for all accesses. There is no outstanding-request queue.
- Reset values:
  - req_ready = 0 in the reset cycle.
  - rsp_valid = 0, rsp_rdata = 0.
  - mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - State IDLE, last_grant = 1 (CPU wins the first tie), lock_cnt = 0, owner = 0.
- Reset mid-burst drops the lock. A response pending from the cycle before reset is discarded: rsp_valid = 0 in the cycle after reset is asserted.
- LOCK_MAX = 1: locking is inert and the FSM never leaves IDLE.
- No-request cycle: no state change, except that LOCKED persists.

## Configuration
- DMEM_ARB_ROUND_ROBIN_EN
  - Defined: tie rule is round-robin as above.
  - Undefined: fixed priority, requester 0 always wins ties in IDLE. last_grant is still tracked but unused. The forced-release rule still applies, but the CPU wins the following tie.

## Structure
- Package dmem_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t
  - typedef enum logic {REQ_CPU = 0, REQ_LOADER = 1} req_id_t
- Sub-module rr_pick_2:
  - Pure combinational 2-way grant.
  - Inputs: valid[1:0], last, prio_en.
  - Output: one-hot grant.
  - Reused by any later shared resource.

## Test plan
- Solo CPU read: valid[0], addr 0x10; memory holds 0xDEADBEEF at 0x10 → ready[0] = 1 in the same cycle, mem_en = 1, rsp_valid[0] = 1 next cycle with rdata 0xDEADBEEF.
- Both requesters valid for 4 cycles after reset, all reads → grants 0,1,0,1. Each rsp_valid follows its grant by 1 cycle. With the macro undefined → grants 0,0,0,0.
- Loader burst with req_lock = 1 on 3 writes to 0x0, 0x4, 0x8, then lock = 0 on the 4th; CPU valid throughout → CPU ready = 0 for 4 beats, CPU granted on the 5th cycle.
- Loader holds lock = 1 indefinitely with LOCK_MAX = 8; CPU valid → forced release after the 8th beat, CPU granted on the next cycle.
- rst asserted in the cycle after an accepted read → rsp_valid = 0 in that cycle and all outputs at reset values. The first post-reset tie goes to the CPU.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types for the data-memory arbiter: FSM state encoding, requester
// identifiers and a small helper that turns a one-hot 2-way grant into the
// winning requester id.
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_CPU    = 1'b0,
        REQ_LOADER = 1'b1
    } req_id_t;

    // One-hot (or zero) grant to requester id. A zero grant maps to REQ_CPU;
    // callers qualify the result with "any grant".
    function automatic req_id_t grant_to_id(input logic [NUM_REQ-1:0] grant);
        return grant[1] ? REQ_LOADER : REQ_CPU;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the two requester channels and the single-port memory channel of
// the data-memory arbiter.
//   req_valid/ready/we/lock [1:0]   per-requester handshake and qualifiers
//   req_addr/req_wdata     [1:0]    per-requester address and write data
//   rsp_valid [1:0], rsp_rdata      response strobe and shared read data
//   mem_en/we/addr/wdata, mem_rdata single-port memory access
// Modports:
//   slave  - the arbiter
//   master - requesters plus the memory (the surrounding system / bench)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [1:0]                 req_valid;
    logic [1:0]                 req_ready;
    logic [1:0]                 req_we;
    logic [1:0]                 req_lock;
    logic [1:0][ADDR_WIDTH-1:0] req_addr;
    logic [1:0][DATA_WIDTH-1:0] req_wdata;

    logic [1:0]                 rsp_valid;
    logic [DATA_WIDTH-1:0]      rsp_rdata;

    logic                       mem_en;
    logic                       mem_we;
    logic [ADDR_WIDTH-1:0]      mem_addr;
    logic [DATA_WIDTH-1:0]      mem_wdata;
    logic [DATA_WIDTH-1:0]      mem_rdata;

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick_2
// Purely combinational 2-way grant picker.
//   valid[1:0]  requests
//   last        requester granted last time (round-robin pointer)
//   prio_en     1 = fixed priority (requester 0 wins ties), 0 = round-robin
//   grant[1:0]  one-hot grant, zero when nothing is valid
// -----------------------------------------------------------------------------
module rr_pick_2 (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic       prio_en,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Tie: requester 0 wins under fixed priority, otherwise whoever
            // did not win last time.
            2'b11:   grant = (prio_en || last) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-requester arbiter/sequencer for the single-port data memory.
// Requester 0 is the CPU load/store path, requester 1 the loader/debug port.
// One access is accepted per cycle; the loader (or CPU) may hold the grant
// for up to LOCK_MAX beats with req_lock. The response strobe and read data
// come back exactly one cycle after acceptance.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   dmem_arbiter_if.slave (requester channels + memory channel)
//
// Parameters:
//   ADDR_WIDTH, DATA_WIDTH  must match the connected interface instance
//   LOCK_MAX                maximum beats per locked burst (>= 1)
//
// Configuration macro:
//   DMEM_ARB_ROUND_ROBIN_EN  defined   -> round-robin tie break in IDLE
//                            undefined -> requester 0 always wins ties
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 8
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam int              CNT_W      = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);
    // A one-beat lock is meaningless, so locking is disabled altogether.
    localparam bit              LOCK_EN    = (LOCK_MAX > 1);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam logic PRIO_EN = 1'b0;
`else
    localparam logic PRIO_EN = 1'b1;
`endif

    // Registered state
    arb_state_t        r_state;
    req_id_t           r_owner;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_lock_cnt;
    logic [1:0]        r_rsp_valid;
    logic              r_rsp_read;

    // Next-state values
    arb_state_t        w_state_next;
    req_id_t           w_owner_next;
    logic              w_last_grant_next;
    logic [CNT_W-1:0]  w_lock_cnt_next;
    logic [1:0]        w_rsp_valid_next;
    logic              w_rsp_read_next;

    // Grant path
    logic [1:0]        w_idle_grant;
    logic [1:0]        w_lock_grant;
    logic [1:0]        w_grant;
    logic              w_accept;
    req_id_t           w_winner;
    logic              w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    // -------------------------------------------------------------------------
    // Grant selection
    // -------------------------------------------------------------------------
    rr_pick_2 u_pick (
        .valid   (bus.req_valid),
        .last    (r_last_grant),
        .prio_en (PRIO_EN),
        .grant   (w_idle_grant)
    );

    // While locked only the owner may be accepted; it is not re-arbitrated
    // even in cycles where the owner has nothing to send.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lock_grant
        assign w_lock_grant[gi] = (r_owner == ((gi == 1) ? REQ_LOADER : REQ_CPU))
                                  && bus.req_valid[gi];
    end

    assign w_grant  = rst                     ? 2'b00 :
                      (r_state == ARB_IDLE)   ? w_idle_grant :
                                                w_lock_grant;
    assign w_accept = |w_grant;
    assign w_winner = grant_to_id(w_grant);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_owner      <= REQ_CPU;
            r_last_grant <= 1'b1;      // CPU wins the first tie
            r_lock_cnt   <= '0;
            r_rsp_valid  <= 2'b00;
            r_rsp_read   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_last_grant <= w_last_grant_next;
            r_lock_cnt   <= w_lock_cnt_next;
            r_rsp_valid  <= w_rsp_valid_next;
            r_rsp_read   <= w_rsp_read_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_owner_next      = r_owner;
        w_last_grant_next = r_last_grant;
        w_lock_cnt_next   = r_lock_cnt;
        w_rsp_valid_next  = w_grant;
        w_rsp_read_next   = w_accept && !bus.req_we[w_winner];

        if (w_accept) begin
            case (r_state)
                ARB_IDLE: begin
                    w_last_grant_next = w_winner;
                    if (LOCK_EN && bus.req_lock[w_winner]) begin
                        w_state_next    = ARB_LOCKED;
                        w_owner_next    = w_winner;
                        w_lock_cnt_next = CNT_W'(1);
                    end
                end
                ARB_LOCKED: begin
                    w_lock_cnt_next = r_lock_cnt + CNT_W'(1);
                    if (!bus.req_lock[r_owner]) begin
                        w_state_next    = ARB_IDLE;
                        w_lock_cnt_next = '0;
                    end else if (w_lock_cnt_next == LOCK_MAX_C) begin
                        // Forced release: point the round-robin away from
                        // the owner so the other side wins the next tie.
                        w_state_next      = ARB_IDLE;
                        w_lock_cnt_next   = '0;
                        w_last_grant_next = r_owner;
                    end
                end
                default: w_state_next = ARB_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    assign w_mem_we    = w_accept && bus.req_we[w_winner];
    assign w_mem_addr  = w_accept ? bus.req_addr[w_winner]  : '0;
    assign w_mem_wdata = w_accept ? bus.req_wdata[w_winner] : '0;

    always_comb begin
        bus.req_ready = w_grant;
        bus.mem_en    = w_accept;
        bus.mem_we    = w_mem_we;
        bus.mem_addr  = w_mem_addr;
        bus.mem_wdata = w_mem_wdata;
        // A response registered just before reset must not leak out while
        // reset is held.
        bus.rsp_valid = rst ? 2'b00 : r_rsp_valid;
        bus.rsp_rdata = (!rst && r_rsp_read) ? bus.mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed scenarios followed by randomized traffic. A behavioural model
// (winner choice, lock bookkeeping and a shadow copy of memory) predicts all
// arbiter outputs each cycle; directed scenarios additionally pin both the
// DUT and the model to hand-computed literals.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int LOCK_MAX = 8;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dmem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LOCK_MAX   (LOCK_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int k);
        return (k == 4) ? 32'hDEAD_BEEF : (32'h1000_0000 + 32'(k) * 32'h0001_0203);
    endfunction

    // ------------------------------------------------------------------------
    // Memory environment: single port, read data one cycle after mem_en
    // ------------------------------------------------------------------------
    logic [31:0] bmem [256];
    bit          bmem_init = 1'b0;

    always @(posedge clk) begin
        if (!bmem_init) begin
            for (int k = 0; k < 256; k++) bmem[k] <= init_word(k);
            bus.mem_rdata <= '0;
            bmem_init     <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) bmem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            else            bus.mem_rdata <= bmem[bus.mem_addr[9:2]];
        end
    end

    // ------------------------------------------------------------------------
    // Behavioural model + per-cycle compare (at negedge)
    // ------------------------------------------------------------------------
    logic [31:0] shadow [256];
    bit          sh_init  = 1'b0;
    bit          m_locked;
    int          m_owner, m_last, m_beats;
    logic [1:0]  m_rsp_v;
    logic [31:0] m_rsp_d;

    logic [1:0]  exp_ready;
    logic        exp_en, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [1:0]  exp_rsp_v;
    logic [31:0] exp_rsp_d;

    always @(negedge clk) begin
        int win;
        if (!sh_init) begin
            for (int k = 0; k < 256; k++) shadow[k] = init_word(k);
            m_locked = 1'b0; m_owner = 0; m_last = 1; m_beats = 0;
            m_rsp_v  = 2'b00; m_rsp_d = '0;
            sh_init  = 1'b1;
        end

        win = -1;
        if (!rst) begin
            if (m_locked) begin
                if (bus.req_valid[m_owner]) win = m_owner;
            end else if (bus.req_valid == 2'b11) begin
                win = (RR && m_last == 0) ? 1 : 0;
            end else if (bus.req_valid[0]) begin
                win = 0;
            end else if (bus.req_valid[1]) begin
                win = 1;
            end
        end

        exp_ready = (win < 0) ? 2'b00 : ((win == 0) ? 2'b01 : 2'b10);
        exp_en    = (win >= 0);
        exp_we    = (win >= 0) ? bus.req_we[win]    : 1'b0;
        exp_addr  = (win >= 0) ? bus.req_addr[win]  : 32'h0;
        exp_wdata = (win >= 0) ? bus.req_wdata[win] : 32'h0;
        exp_rsp_v = rst ? 2'b00 : m_rsp_v;
        exp_rsp_d = rst ? 32'h0 : m_rsp_d;

        chk("req_ready", bus.req_ready, exp_ready);
        chk("mem_en",    bus.mem_en,    exp_en);
        chk("mem_we",    bus.mem_we,    exp_we);
        chk("mem_addr",  bus.mem_addr,  exp_addr);
        chk("mem_wdata", bus.mem_wdata, exp_wdata);
        chk("rsp_valid", bus.rsp_valid, exp_rsp_v);
        chk("rsp_rdata", bus.rsp_rdata, exp_rsp_d);

        if (rst) begin
            m_locked = 1'b0; m_owner = 0; m_last = 1; m_beats = 0;
            m_rsp_v  = 2'b00; m_rsp_d = '0;
        end else begin
            m_rsp_v = exp_ready;
            m_rsp_d = 32'h0;
            if (win >= 0) begin
                if (exp_we) shadow[exp_addr[9:2]] = exp_wdata;
                else        m_rsp_d = shadow[exp_addr[9:2]];
                if (!m_locked) begin
                    m_last = win;
                    if (bus.req_lock[win] && LOCK_MAX > 1) begin
                        m_locked = 1'b1; m_owner = win; m_beats = 1;
                    end
                end else begin
                    m_beats++;
                    if (!bus.req_lock[win] || m_beats == LOCK_MAX) begin
                        m_locked = 1'b0; m_beats = 0; m_last = m_owner;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic cyc(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic r);
        @(posedge clk);
        #1;
        rst              = r;
        bus.req_valid    = v;
        bus.req_we       = we;
        bus.req_lock     = lk;
        bus.req_addr[0]  = a0;
        bus.req_addr[1]  = a1;
        bus.req_wdata[0] = d0;
        bus.req_wdata[1] = d1;
        @(negedge clk);
        #1;
    endtask

    // Pin DUT and model to a literal
    task automatic lit(input string n, input logic [63:0] dut_v, input logic [63:0] mdl_v,
                       input logic [63:0] want);
        chk(n, dut_v, want);
        chk({n, "_model"}, mdl_v, want);
    endtask

    logic [1:0] tie_seq [4];
    logic [1:0] prev_r;
    bit [1:0]   pend;

    initial begin
        bus.req_valid = 2'b00; bus.req_we = 2'b00; bus.req_lock = 2'b00;
        bus.req_addr  = '0;    bus.req_wdata = '0;

        // Reset: nothing accepted even with both requesting
        cyc(2'b11, 2'b00, 2'b00, 32'h10, 32'h14, 0, 0, 1'b1);
        lit("rst_ready", bus.req_ready, exp_ready, 2'b00);
        cyc(2'b11, 2'b00, 2'b00, 32'h10, 32'h14, 0, 0, 1'b1);
        lit("rst_mem_en", bus.mem_en, exp_en, 1'b0);
        lit("rst_rsp_valid", bus.rsp_valid, exp_rsp_v, 2'b00);

        // Solo CPU read of 0x10
        cyc(2'b01, 2'b00, 2'b00, 32'h10, 32'h0, 0, 0, 1'b0);
        lit("solo_ready", bus.req_ready, exp_ready, 2'b01);
        lit("solo_mem_addr", bus.mem_addr, exp_addr, 32'h10);
        cyc(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 0, 0, 1'b0);
        lit("solo_rsp_valid", bus.rsp_valid, exp_rsp_v, 2'b01);
        lit("solo_rsp_rdata", bus.rsp_rdata, exp_rsp_d, 32'hDEAD_BEEF);

        // Tie sequence after reset
        cyc(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
        if (RR) begin
            tie_seq[0] = 2'b01; tie_seq[1] = 2'b10; tie_seq[2] = 2'b01; tie_seq[3] = 2'b10;
        end else begin
            tie_seq[0] = 2'b01; tie_seq[1] = 2'b01; tie_seq[2] = 2'b01; tie_seq[3] = 2'b01;
        end
        prev_r = 2'b00;
        for (int k = 0; k < 4; k++) begin
            cyc(2'b11, 2'b00, 2'b00, 32'h20, 32'h24, 0, 0, 1'b0);
            lit("tie_ready", bus.req_ready, exp_ready, tie_seq[k]);
            lit("tie_rsp_valid", bus.rsp_valid, exp_rsp_v, prev_r);
            prev_r = tie_seq[k];
        end
        cyc(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
        lit("tie_rsp_last", bus.rsp_valid, exp_rsp_v, prev_r);

        // Loader locked burst: 3 locked writes then an unlocked 4th
        cyc(2'b10, 2'b10, 2'b10, 32'h0, 32'h0, 0, 32'h1111_0000, 1'b0);
        lit("burst_b1_ready", bus.req_ready, exp_ready, 2'b10);
        lit("burst_b1_wdata", bus.mem_wdata, exp_wdata, 32'h1111_0000);
        cyc(2'b11, 2'b10, 2'b10, 32'h0, 32'h4, 0, 32'h2222_0000, 1'b0);
        lit("burst_b2_ready", bus.req_ready, exp_ready, 2'b10);
        cyc(2'b11, 2'b10, 2'b10, 32'h0, 32'h8, 0, 32'h3333_0000, 1'b0);
        lit("burst_b3_ready", bus.req_ready, exp_ready, 2'b10);
        cyc(2'b11, 2'b10, 2'b00, 32'h0, 32'hC, 0, 32'h4444_0000, 1'b0);
        lit("burst_b4_ready", bus.req_ready, exp_ready, 2'b10);
        cyc(2'b01, 2'b00, 2'b00, 32'h0, 32'h0, 0, 0, 1'b0);
        lit("burst_cpu_ready", bus.req_ready, exp_ready, 2'b01);
        cyc(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
        lit("burst_cpu_rdata", bus.rsp_rdata, exp_rsp_d, 32'h1111_0000);

        // Indefinite lock: forced release after LOCK_MAX beats
        cyc(2'b10, 2'b10, 2'b10, 32'h40, 32'h40, 0, 32'h5555_0001, 1'b0);
        lit("force_c1", bus.req_ready, exp_ready, 2'b10);
        for (int k = 0; k < 2; k++) begin
            cyc(2'b11, 2'b10, 2'b10, 32'h40, 32'h44 + 32'(4 * k), 0, 32'h5555_0002, 1'b0);
            lit("force_early", bus.req_ready, exp_ready, 2'b10);
        end
        cyc(2'b01, 2'b00, 2'b10, 32'h40, 32'h0, 0, 0, 1'b0);
        lit("force_owner_idle", bus.req_ready, exp_ready, 2'b00);
        for (int k = 0; k < 5; k++) begin
            cyc(2'b11, 2'b10, 2'b10, 32'h40, 32'h50 + 32'(4 * k), 0, 32'h5555_0003, 1'b0);
            lit("force_late", bus.req_ready, exp_ready, 2'b10);
        end
        cyc(2'b11, 2'b10, 2'b10, 32'h40, 32'h80, 0, 32'h5555_0004, 1'b0);
        lit("force_cpu_wins", bus.req_ready, exp_ready, 2'b01);
        cyc(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0);

        // Reset right after an accepted read
        cyc(2'b01, 2'b00, 2'b00, 32'h10, 32'h24, 0, 0, 1'b0);
        lit("rr_read_ready", bus.req_ready, exp_ready, 2'b01);
        cyc(2'b11, 2'b10, 2'b00, 32'h10, 32'h24, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 1'b1);
        lit("rr_rsp_valid", bus.rsp_valid, exp_rsp_v, 2'b00);
        lit("rr_rsp_rdata", bus.rsp_rdata, exp_rsp_d, 32'h0);
        lit("rr_ready", bus.req_ready, exp_ready, 2'b00);
        lit("rr_mem_addr", bus.mem_addr, exp_addr, 32'h0);
        lit("rr_mem_wdata", bus.mem_wdata, exp_wdata, 32'h0);
        cyc(2'b11, 2'b00, 2'b00, 32'h10, 32'h24, 0, 0, 1'b0);
        lit("rr_first_tie", bus.req_ready, exp_ready, 2'b01);

        // Randomized traffic; requesters hold a request until it is accepted
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                pend[i] = bus.req_valid[i] && !exp_ready[i] && !rst;
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    bus.req_valid[i] = ($urandom_range(0, 9) < 6);
                    bus.req_we[i]    = 1'($urandom_range(0, 1));
                    bus.req_lock[i]  = (i == 1) ? ($urandom_range(0, 9) < 7)
                                                : ($urandom_range(0, 9) < 2);
                    bus.req_addr[i]  = $urandom;
                    bus.req_wdata[i] = $urandom;
                end
            end
        end

        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = 2'b00;
        @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
